// File: rtl/collision_matrix_manager.sv
// Collision matrix manager: per-frame overlap detection between the player car
// layer and NUM_OBJ object layers, with edge-detected collision events,
// sticky flags and saturating event counters.
// Optional build macro COLLISION_OVERLAP_COUNT_EN adds per-channel 16-bit
// overlap pixel counters latched on every frame commit.
//
// state    | meaning
// S_WAIT   | idle after reset; pixels ignored, first frame_start opens a frame
// S_ACCUM  | accumulating hits for the current frame
// S_FREEZE | game paused; no accumulation, commits still happen
module collision_matrix_manager #(
   parameter int                 NUM_OBJ    = 4,
   parameter int                 COLOR_W    = 8,
   parameter logic [COLOR_W-1:0] MASK_VALUE = 8'h62,
   parameter int                 CNT_W      = 4
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       frame_start,
   input  logic                       pixel_valid,
   input  logic                       freeze,
   input  logic [COLOR_W-1:0]         player_color,
   input  logic [NUM_OBJ*COLOR_W-1:0] obj_colors,
   input  logic [NUM_OBJ-1:0]         ack,
   output logic [NUM_OBJ-1:0]         hit_frame,
   output logic [NUM_OBJ-1:0]         collision_pulse,
   output logic [NUM_OBJ-1:0]         collision_evt,
   output logic                       any_hit,
   output logic [3:0]                 first_hit,
   output logic [NUM_OBJ*CNT_W-1:0]   evt_count,
   output logic [NUM_OBJ*16-1:0]      overlap_pixels
);

   typedef enum logic [1:0] {S_WAIT, S_ACCUM, S_FREEZE} state_t;

   state_t               r_state, w_state_nxt;
   logic [NUM_OBJ-1:0]   w_hit, w_new_hit;
   logic                 w_commit, w_accum;
   logic [NUM_OBJ-1:0]   r_hit_acc, r_hit_frame, r_prev_frame, r_evt;
   logic                 r_commit_q;
   logic [NUM_OBJ*CNT_W-1:0] r_evt_count;

   // Per-pixel overlap test for every channel
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         w_hit[i] = pixel_valid && (player_color != MASK_VALUE) &&
                    (obj_colors[i*COLOR_W +: COLOR_W] != MASK_VALUE);
      end
   end

   // The frame_start pixel seeds the new frame; a paused game contributes nothing
   assign w_new_hit = w_hit & ~{NUM_OBJ{freeze}};
   assign w_commit  = frame_start && (r_state != S_WAIT);
   assign w_accum   = (r_state == S_ACCUM) && !freeze;

   // FSM state register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= S_WAIT;
      else         r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_WAIT:   if (frame_start) w_state_nxt = S_ACCUM;
         S_ACCUM:  if (freeze)      w_state_nxt = S_FREEZE;
         S_FREEZE: if (!freeze)     w_state_nxt = S_ACCUM;
         default:                   w_state_nxt = S_WAIT;
      endcase
   end

   // Hit accumulation and frame commit
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_hit_acc    <= '0;
         r_hit_frame  <= '0;
         r_prev_frame <= '0;
         r_commit_q   <= 1'b0;
      end else begin
         r_commit_q <= w_commit;
         if (frame_start)  r_hit_acc <= w_new_hit;
         else if (w_accum) r_hit_acc <= r_hit_acc | w_hit;
         if (w_commit) begin
            r_hit_frame  <= r_hit_acc;
            r_prev_frame <= r_hit_frame;
         end
      end
   end

   // Rising edge of a channel's frame result, valid only right after a commit
   assign collision_pulse = r_hit_frame & ~r_prev_frame & {NUM_OBJ{r_commit_q}};

   // Sticky event flags (set beats ack) and saturating event counters
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_evt       <= '0;
         r_evt_count <= '0;
      end else begin
         r_evt <= (r_evt & ~ack) | collision_pulse;
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (collision_pulse[i] && (r_evt_count[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
               r_evt_count[i*CNT_W +: CNT_W] <= r_evt_count[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

   // Lowest-index hit channel of the last frame
   always_comb begin
      first_hit = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (r_hit_frame[i]) first_hit = 4'(i);
      end
   end

   assign any_hit       = |r_hit_frame;
   assign hit_frame     = r_hit_frame;
   assign collision_evt = r_evt;
   assign evt_count     = r_evt_count;

`ifdef COLLISION_OVERLAP_COUNT_EN
   logic [NUM_OBJ*16-1:0] r_ovl_acc, r_ovl;

   // Overlap pixel counters follow the same frame boundaries as hit_acc
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_ovl_acc <= '0;
         r_ovl     <= '0;
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (frame_start)
               r_ovl_acc[i*16 +: 16] <= {15'd0, w_new_hit[i]};
            else if (w_accum && w_hit[i] && (r_ovl_acc[i*16 +: 16] != 16'hFFFF))
               r_ovl_acc[i*16 +: 16] <= r_ovl_acc[i*16 +: 16] + 16'd1;
            if (w_commit)
               r_ovl[i*16 +: 16] <= r_ovl_acc[i*16 +: 16];
         end
      end
   end

   assign overlap_pixels = r_ovl;
`else
   assign overlap_pixels = '0;
`endif

endmodule

// File: tb/tb_collision_matrix_manager.sv
// Directed bench for collision_matrix_manager (default parameters).
module tb_collision_matrix_manager;

   localparam logic [7:0] M = 8'h62;

   logic        clk, resetN, frame_start, pixel_valid, freeze;
   logic [7:0]  player_color;
   logic [31:0] obj_colors;
   logic [3:0]  ack;
   logic [3:0]  hit_frame, collision_pulse, collision_evt, first_hit;
   logic        any_hit;
   logic [15:0] evt_count;
   logic [63:0] overlap_pixels;

   int n_cmp = 0;
   int n_err = 0;

   collision_matrix_manager dut (
      .clk(clk), .resetN(resetN), .frame_start(frame_start),
      .pixel_valid(pixel_valid), .freeze(freeze), .player_color(player_color),
      .obj_colors(obj_colors), .ack(ack), .hit_frame(hit_frame),
      .collision_pulse(collision_pulse), .collision_evt(collision_evt),
      .any_hit(any_hit), .first_hit(first_hit), .evt_count(evt_count),
      .overlap_pixels(overlap_pixels)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ovl(input string tag, input int ch, input logic [15:0] exp);
`ifdef COLLISION_OVERLAP_COUNT_EN
      chk(tag, 64'(overlap_pixels[ch*16 +: 16]), 64'(exp));
`else
      chk(tag, overlap_pixels, 64'd0);
`endif
   endtask

   initial begin
      resetN = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0; freeze = 1'b0;
      player_color = M; obj_colors = {M, M, M, M}; ack = 4'b0;
      tick; tick;
      chk("rst_hit_frame", 64'(hit_frame), 64'h0);
      chk("rst_pulse", 64'(collision_pulse), 64'h0);
      chk("rst_evt", 64'(collision_evt), 64'h0);
      chk("rst_count", 64'(evt_count), 64'h0);
      chk("rst_any", 64'(any_hit), 64'h0);
      chk("rst_first", 64'(first_hit), 64'h0);
      chk("rst_ovl", overlap_pixels, 64'h0);
      resetN = 1'b1;
      tick;

      // three hit pixels on channel 2
      frame_start = 1'b1; tick; frame_start = 1'b0;
      pixel_valid = 1'b1; player_color = 8'h10; obj_colors = {M, 8'h20, M, M};
      tick; tick; tick;
      pixel_valid = 1'b0; tick;
      frame_start = 1'b1; tick;
      chk("f1_hit_frame", 64'(hit_frame), 64'h4);
      chk("f1_first", 64'(first_hit), 64'd2);
      chk("f1_any", 64'(any_hit), 64'd1);
      chk("f1_pulse", 64'(collision_pulse), 64'h4);
      chk_ovl("f1_ovl2", 2, 16'd3);
      frame_start = 1'b0; tick;
      chk("f1_pulse_gone", 64'(collision_pulse), 64'h0);
      chk("f1_evt", 64'(collision_evt), 64'h4);
      chk("f1_count", 64'(evt_count), 64'h0100);

      // same channel again: no new event
      pixel_valid = 1'b1; tick; pixel_valid = 1'b0;
      frame_start = 1'b1; tick;
      chk("f2_hit_frame", 64'(hit_frame), 64'h4);
      chk("f2_pulse", 64'(collision_pulse), 64'h0);
      chk_ovl("f2_ovl2", 2, 16'd1);
      frame_start = 1'b0; tick;
      chk("f2_count", 64'(evt_count), 64'h0100);
      chk("f2_evt_sticky", 64'(collision_evt), 64'h4);
      ack = 4'b0100; tick; ack = 4'b0;
      chk("f2_evt_acked", 64'(collision_evt), 64'h0);

      // empty frame, then hit frame with ack colliding with the pulse
      frame_start = 1'b1; tick; frame_start = 1'b0;
      chk("f3_hit_frame", 64'(hit_frame), 64'h0);
      pixel_valid = 1'b1; tick; pixel_valid = 1'b0;
      frame_start = 1'b1; tick;
      chk("f4_pulse", 64'(collision_pulse), 64'h4);
      frame_start = 1'b0; ack = 4'b0100; tick; ack = 4'b0;
      chk("f4_set_wins", 64'(collision_evt), 64'h4);
      chk("f4_count", 64'(evt_count), 64'h0200);

      // transparent player: no hits
      player_color = M; obj_colors = {8'h11, 8'h11, 8'h11, 8'h11};
      pixel_valid = 1'b1; tick; tick; pixel_valid = 1'b0;
      frame_start = 1'b1; tick; frame_start = 1'b0;
      chk("f5_hit_frame", 64'(hit_frame), 64'h0);
      chk("f5_any", 64'(any_hit), 64'h0);
      chk("f5_first", 64'(first_hit), 64'h0);

      // frozen frame with hits present
      freeze = 1'b1; player_color = 8'h10; pixel_valid = 1'b1;
      tick; tick; tick;
      pixel_valid = 1'b0; frame_start = 1'b1; tick; frame_start = 1'b0;
      chk("f6_frozen_hit_frame", 64'(hit_frame), 64'h0);
      chk("f6_frozen_any", 64'(any_hit), 64'h0);
      freeze = 1'b0; tick;

      // 20 events on channel 0 saturate the counter
      obj_colors = {M, M, M, 8'h11};
      for (int k = 0; k < 20; k++) begin
         pixel_valid = 1'b1; tick; pixel_valid = 1'b0;
         frame_start = 1'b1; tick; frame_start = 1'b0; tick;
         frame_start = 1'b1; tick; frame_start = 1'b0;
      end
      chk("sat_count", 64'(evt_count), 64'h020F);
      chk("sat_evt", 64'(collision_evt), 64'h5);

      // frame boundary: pixel before frame_start is old, frame_start pixel is new
      obj_colors = {M, M, 8'h22, M}; pixel_valid = 1'b1; tick;
      obj_colors = {8'h33, M, M, M}; frame_start = 1'b1; tick;
      chk("bnd_old_frame", 64'(hit_frame), 64'h2);
      chk("bnd_first1", 64'(first_hit), 64'd1);
      chk("bnd_pulse1", 64'(collision_pulse), 64'h2);
      chk_ovl("bnd_ovl1", 1, 16'd1);
      chk_ovl("bnd_ovl3_old", 3, 16'd0);
      frame_start = 1'b0; pixel_valid = 1'b0; tick; tick;
      frame_start = 1'b1; tick; frame_start = 1'b0;
      chk("bnd_new_frame", 64'(hit_frame), 64'h8);
      chk("bnd_first3", 64'(first_hit), 64'd3);
      chk("bnd_pulse3", 64'(collision_pulse), 64'h8);
      chk_ovl("bnd_ovl3_new", 3, 16'd1);
      tick;

      // reset mid-frame
      obj_colors = {M, M, M, 8'h44}; pixel_valid = 1'b1; tick; tick; pixel_valid = 1'b0;
      #2 resetN = 1'b0;
      #1;
      chk("mid_rst_hit_frame", 64'(hit_frame), 64'h0);
      chk("mid_rst_evt", 64'(collision_evt), 64'h0);
      chk("mid_rst_count", 64'(evt_count), 64'h0);
      chk("mid_rst_ovl", overlap_pixels, 64'h0);
      chk("mid_rst_any", 64'(any_hit), 64'h0);
      tick; resetN = 1'b1; tick;
      frame_start = 1'b1; tick; frame_start = 1'b0;
      chk("post_rst_no_commit", 64'(hit_frame), 64'h0);
      chk("post_rst_no_pulse", 64'(collision_pulse), 64'h0);
      pixel_valid = 1'b1; tick; tick; pixel_valid = 1'b0;
      frame_start = 1'b1; tick; frame_start = 1'b0;
      chk("post_rst_hit_frame", 64'(hit_frame), 64'h1);
      chk("post_rst_pulse", 64'(collision_pulse), 64'h1);
      chk_ovl("post_rst_ovl0", 0, 16'd2);
      tick;
      chk("post_rst_count", 64'(evt_count), 64'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/collision_matrix_manager.md
COLLISION_MATRIX_MANAGER -- requirements
Module: collision_matrix_manager

Interface
REQ-001 Parameter NUM_OBJ, default 4, number of object channels tested against the player car (1..16).
REQ-002 Parameter COLOR_W, default 8, pixel color width.
REQ-003 Parameter MASK_VALUE, default 8'h62, transparent color code; any other value means the layer is drawn.
REQ-004 Parameter CNT_W, default 4, width of each per-channel saturating event counter.
REQ-005 clk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-006 resetN  in  1  reset; asynchronous, active-low.
REQ-007 frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-008 pixel_valid  in  1  high when the current cycle carries a visible pixel.
REQ-009 freeze  in  1  game pause; no accumulation while high.
REQ-010 player_color  in  COLOR_W  player car layer color at the current pixel.
REQ-011 obj_colors  in  NUM_OBJ*COLOR_W  object layer colors; channel i occupies bits [i*COLOR_W +: COLOR_W].
REQ-012 ack  in  NUM_OBJ  per-channel clear of the sticky event flag.
REQ-013 hit_frame  out  NUM_OBJ  per-channel overlap result of the last completed frame.
REQ-014 collision_pulse  out  NUM_OBJ  one-cycle pulse when a channel starts colliding.
REQ-015 collision_evt  out  NUM_OBJ  sticky event flags.
REQ-016 any_hit  out  1  OR of hit_frame.
REQ-017 first_hit  out  4  index of the lowest set bit of hit_frame; 0 when none.
REQ-018 evt_count  out  NUM_OBJ*CNT_W  per-channel saturating event counts.
REQ-019 overlap_pixels  out  NUM_OBJ*16  per-channel overlap pixel counts of the last frame.

Function
REQ-020 The FSM SHALL have states S_WAIT, S_ACCUM and S_FREEZE; it SHALL reset to S_WAIT.
REQ-021 S_WAIT: pixels are ignored; frame_start moves the FSM to S_ACCUM and SHALL NOT commit.
REQ-022 S_ACCUM: freeze=1 moves the FSM to S_FREEZE; S_FREEZE with freeze=0 returns to S_ACCUM; frame_start commits in both states.
REQ-023 Per-pixel hit for channel i = pixel_valid & player_color!=MASK_VALUE & obj color i!=MASK_VALUE.
REQ-024 In S_ACCUM (freeze=0), a hit SHALL set hit_acc[i] at the following edge (one-cycle latency).
REQ-025 A pixel sampled in a frame_start cycle SHALL belong to the new frame.
REQ-026 On a frame_start commit: hit_frame<=hit_acc; hit_acc<=hit of the current pixel; prev_frame<=old hit_frame; all updates visible the next cycle.
REQ-027 collision_pulse[i] SHALL be high for exactly the cycle after a commit where the new hit_frame[i]=1 and the previous hit_frame[i]=0.
REQ-028 collision_evt[i] SHALL be set by collision_pulse[i] and cleared by ack[i]; when both occur in the same cycle, set SHALL win.
REQ-029 evt_count[i] SHALL increment on each collision_pulse[i] and saturate at all-ones.
REQ-030 any_hit and first_hit SHALL be combinational from hit_frame.
REQ-031 The freeze input SHALL NOT block commits, pulses or acks.

Reset
REQ-032 resetN=0 SHALL asynchronously clear the FSM to S_WAIT and clear hit_acc, hit_frame, prev_frame, collision_pulse, collision_evt, evt_count and overlap_pixels.
REQ-033 Reset asserted mid-frame SHALL discard the partial accumulation, and the first frame_start after release SHALL NOT commit.

Configuration
REQ-034 Macro COLLISION_OVERLAP_COUNT_EN defined: a per-channel 16-bit overlap accumulator SHALL count hit pixels under the rules of REQ-024/025, saturate at 16'hFFFF, and be latched to overlap_pixels on each commit.
REQ-035 Macro COLLISION_OVERLAP_COUNT_EN undefined: no accumulators SHALL be built, and overlap_pixels SHALL be tied to 0.

Verification
REQ-036 Reset, frame_start, then 3 hit pixels on channel 2, then frame_start -> hit_frame=4'b0100, first_hit=2, a single collision_pulse[2], evt_count[2]=1, overlap_pixels[2]=3 (macro defined).
REQ-037 Same channel hits in two consecutive frames -> only one collision_pulse; evt_count stays 1; collision_evt[2] stays 1 until ack.
REQ-038 ack[2] in the same cycle as collision_pulse[2] -> collision_evt[2]=1.
REQ-039 Player color = 8'h62 with all objects drawn -> hit_frame=0 and any_hit=0.
REQ-040 freeze=1 for the entire frame with hits present -> next commit gives hit_frame=0; 20 collision events on a channel with CNT_W=4 -> evt_count=15.
REQ-041 Hit in the cycle before frame_start -> counted in the old frame; hit in the frame_start cycle -> counted in the new frame; resetN pulse mid-frame -> all outputs 0, and the next frame_start does not commit.
